// File: rtl/reg_writeback_unit.sv
// Register-file write side: in-order result FIFO that drains one entry per cycle into the RF write port.
// Optional WB_FORWARD_EN macro adds a combinational youngest-match lookup over pending entries.
module reg_writeback_unit #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [REG_W-1:0]              res_reg_num,
    input  logic [DATA_W-1:0]             res_data,
    input  logic [DATA_W-1:0]             res_data_hi,
    input  logic                          res_hilo,
    input  logic                          drain_hold,
    output logic                          rf_we,
    output logic [REG_W-1:0]              rf_reg_num,
    output logic [DATA_W-1:0]             rf_data,
    output logic                          rf_lo_we,
    output logic                          rf_hi_we,
    output logic [DATA_W-1:0]             rf_hi_data,
    output logic                          state_dec,
    output logic [$clog2(DEPTH):0]        occupancy
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_W-1:0]              fwd_reg_num,
    output logic                          fwd_hit,
    output logic [DATA_W-1:0]             fwd_data
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);
    localparam logic [REG_W-1:0] REG_LO   = REG_W'(30);
    localparam logic [REG_W-1:0] REG_HI   = REG_W'(31);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Entry storage; no reset needed, validity is tracked by the pointers
    logic [REG_W-1:0]  reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DATA_W-1:0] hi_mem   [DEPTH];
    logic              hilo_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              ready_q,  ready_d;

    logic              rf_we_q,      rf_we_d;
    logic              rf_lo_we_q,   rf_lo_we_d;
    logic              rf_hi_we_q,   rf_hi_we_d;
    logic              state_dec_q,  state_dec_d;
    logic [REG_W-1:0]  rf_reg_num_q, rf_reg_num_d;
    logic [DATA_W-1:0] rf_data_q,    rf_data_d;
    logic [DATA_W-1:0] rf_hi_data_q, rf_hi_data_d;

    logic              push_c;
    logic              pop_c;
    logic [REG_W-1:0]  head_reg_c;
    logic [DATA_W-1:0] head_data_c;
    logic [DATA_W-1:0] head_hi_c;
    logic              head_hilo_c;

    // Ready is registered from the next count, so it never admits a push into a full FIFO
    assign push_c = res_valid && ready_q;
    assign pop_c  = (count_q != CNT_ZERO) && !drain_hold;

    assign head_reg_c  = reg_mem[rd_ptr_q];
    assign head_data_c = data_mem[rd_ptr_q];
    assign head_hi_c   = hi_mem[rd_ptr_q];
    assign head_hilo_c = hilo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_c) begin
            reg_mem[wr_ptr_q]  <= res_reg_num;
            data_mem[wr_ptr_q] <= res_data;
            hi_mem[wr_ptr_q]   <= res_data_hi;
            hilo_mem[wr_ptr_q] <= res_hilo;
        end
    end

    // Pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_FULL);
    end

    // Head decode into one-cycle write strobes; address/data hold when idle
    always_comb begin
        rf_we_d      = 1'b0;
        rf_lo_we_d   = 1'b0;
        rf_hi_we_d   = 1'b0;
        state_dec_d  = 1'b0;
        rf_reg_num_d = rf_reg_num_q;
        rf_data_d    = rf_data_q;
        rf_hi_data_d = rf_hi_data_q;
        if (pop_c) begin
            rf_reg_num_d = head_reg_c;
            if (head_hilo_c) begin
                rf_lo_we_d   = 1'b1;
                rf_hi_we_d   = 1'b1;
                rf_data_d    = head_data_c;
                rf_hi_data_d = head_hi_c;
            end else if (head_reg_c == REG_ZERO) begin
                rf_we_d = 1'b0;
            end else if (head_reg_c == REG_LO) begin
                rf_lo_we_d = 1'b1;
                rf_data_d  = head_data_c;
            end else if (head_reg_c == REG_HI) begin
                rf_hi_we_d   = 1'b1;
                rf_hi_data_d = head_data_c;
            end else begin
                rf_we_d     = 1'b1;
                state_dec_d = 1'b1;
                rf_data_d   = head_data_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_lo_we_q   <= 1'b0;
            rf_hi_we_q   <= 1'b0;
            state_dec_q  <= 1'b0;
            rf_reg_num_q <= '0;
            rf_data_q    <= '0;
            rf_hi_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            rf_we_q      <= rf_we_d;
            rf_lo_we_q   <= rf_lo_we_d;
            rf_hi_we_q   <= rf_hi_we_d;
            state_dec_q  <= state_dec_d;
            rf_reg_num_q <= rf_reg_num_d;
            rf_data_q    <= rf_data_d;
            rf_hi_data_q <= rf_hi_data_d;
        end
    end

    assign res_ready  = ready_q;
    assign occupancy  = count_q;
    assign rf_we      = rf_we_q;
    assign rf_lo_we   = rf_lo_we_q;
    assign rf_hi_we   = rf_hi_we_q;
    assign state_dec  = state_dec_q;
    assign rf_reg_num = rf_reg_num_q;
    assign rf_data    = rf_data_q;
    assign rf_hi_data = rf_hi_data_q;

`ifdef WB_FORWARD_EN
    // Walk oldest to youngest so the last match is the youngest pending write
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             fwd_ok;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        fwd_ok   = (fwd_reg_num != REG_ZERO) && (fwd_reg_num != REG_LO) &&
                   (fwd_reg_num != REG_HI);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (fwd_ok && (CNT_W'(i) < count_q) && !hilo_mem[idx] &&
                (reg_mem[idx] == fwd_reg_num)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end
`endif

endmodule
